alu_serial_seq: RTL and testbench
=================================

# alu_serial_seq

Sequencer for the 1-bit serial ALU. It accepts a parallel operation request, latches both operands and the opcode, and runs a priming cycle that sets up the ALU's internal carry. It then streams operand bits LSB-first into the ALU and reassembles the registered result bits into a parallel word. It sits between the CPU control FSM and the `alu_1bit` instance and is the only driver of that ALU's control and operand inputs.

## Interface
- `WIDTH`, 8, operand/result width in bits (≥2); bit counter is `$clog2(WIDTH)` bits.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op`  in  3  000 ADD, 001 SUB, 010 XOR, 011 AND, 100 OR, 101–111 result 0.
- `a`  in  WIDTH  operand 1, latched on accept.
- `b`  in  WIDTH  operand 2, latched on accept.
- `busy`  out  1  high from the accept edge until the final capture edge.
- `done`  out  1  one-cycle pulse; `result` valid from this cycle onward.
- `result`  out  WIDTH  last completed result; held until the next `done`.
- `zero`  out  1  result == 0; present only with ZERO_FLAG_EN.
- `alu_rs1`  out  1  operand 1 bit to the ALU.
- `alu_rs2`  out  1  operand 2 bit to the ALU.
- `alu_op`  out  3  latched opcode.
- `alu_enable`  out  1  ALU bit-step enable.
- `alu_start`  out  1  ALU carry-prime strobe.
- `alu_result`  in  1  registered ALU result bit (one-cycle latency).

## Operation
- FSM states: IDLE, PRIME, SHIFT, DRAIN. Transitions:
  - IDLE → PRIME on `start`.
  - PRIME → SHIFT unconditionally.
  - SHIFT → DRAIN when `cnt == WIDTH-1`.
  - DRAIN → IDLE.
- Accept in IDLE with `start=1`:
  - latch `a`, `b`, `op` into internal shift registers and `alu_op`;
  - `cnt` ← 0; `busy` ← 1.
- PRIME:
  - `alu_enable=1`, `alu_start=1`, `alu_rs1=alu_rs2=0`.
  - Result: the ALU carry becomes 1 for SUB and 0 for all other ops, which clears any stale carry left by the previous operation.
  - The ALU result produced by this cycle is discarded.
- SHIFT:
  - `alu_enable=1`, `alu_start=0`.
  - `alu_rs1`/`alu_rs2` = bit `cnt` of the latched operands (LSB first).
  - `cnt` increments each cycle.
- Capture:
  - `alu_result` is shifted MSB-in into an internal accumulator in every SHIFT cycle except `cnt==0`, and in DRAIN.
  - Exactly WIDTH bits are captured, with bit 0 ending in the LSB.
- DRAIN:
  - `alu_enable=0`.
  - Final capture; `result` ← assembled word; `done` ← 1; `busy` ← 0.
- IDLE outputs: `alu_enable=0`, `alu_start=0`, `alu_rs1=alu_rs2=0`; `alu_op` holds its last value.
- `start` while not IDLE: ignored, not queued. `a`/`b`/`op` changes while busy have no effect.
- `start` in the cycle `done` is high: the FSM is in IDLE, so the request is accepted.
- Arithmetic is modulo 2^WIDTH. There is no carry or overflow output.
- Opcodes 101–111 run the full sequence and produce `result=0`.

## Timing
- Let edge E0 be the edge that samples `start`.
  - PRIME occupies the cycle after E0.
  - SHIFT bit k occupies the cycle after edge E(k+1).
  - DRAIN occupies the cycle after edge E(WIDTH+1).
  - `done`, `result` and `zero` are registered at edge E(WIDTH+2).
- Start-to-done latency: WIDTH+2 clocks. Minimum issue interval: WIDTH+2 clocks.
- `busy` is high for exactly WIDTH+2 cycles per operation.
- Reset values: `busy=0`, `done=0`, `result=0`, `zero=0`, `alu_rs1=0`, `alu_rs2=0`, `alu_op=000`, `alu_enable=0`, `alu_start=0`; state IDLE; `cnt=0`.
- Reset mid-operation: everything returns to the reset values immediately. No `done` is produced and the partial result is lost. The ALU shares `rst_n`, so its carry is also cleared.

## Configuration
- `ALU_SEQ_ZERO_FLAG_EN` defined:
  - `zero` port exists; a sticky OR of the captured bits is cleared on accept.
  - `zero` is registered with `result` at the `done` edge and holds until the next `done`.
- Undefined: `zero` port and its logic are absent. All other behaviour and timing are identical.

## Test plan
- ADD, WIDTH=8, a=8'h3C, b=8'h05 → `done` 10 clocks after the accept edge, `result=8'h41`, `busy` high for 10 cycles.
- SUB a=8'h05, b=8'h07 → `result=8'hFE`. Immediately after, ADD a=8'h01, b=8'h01 is accepted in the `done` cycle → `result=8'h02`, proving PRIME clears the stale SUB carry.
- XOR/AND/OR with a=8'hC3, b=8'hA5 → 8'h66 / 8'h81 / 8'hE7. Opcode 3'b111 → 8'h00.
- `start` pulsed with a=8'hFF at cycle 3 of an ADD of 8'h10+8'h20 → ignored; `result=8'h30`; exactly one `done`.
- `rst_n` asserted during SHIFT → all outputs 0 at once, no `done`. A following ADD 8'h01+8'h02 → `result=8'h03`.
- With ALU_SEQ_ZERO_FLAG_EN: SUB 8'h55−8'h55 → `result=0`, `zero=1`. Next ADD 8'h00+8'h01 → `zero=0`.

Source files
------------

// File: rtl/alu_serial_seq.sv
// Sequencer for the 1-bit serial ALU: latches a parallel request, primes the ALU carry,
// streams operand bits LSB-first and reassembles the result. Optional zero flag: ALU_SEQ_ZERO_FLAG_EN.
module alu_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output logic             o_zero,
`endif
    output logic             o_alu_rs1,
    output logic             o_alu_rs2,
    output logic [2:0]       o_alu_op,
    output logic             o_alu_enable,
    output logic             o_alu_start,
    input  logic             i_alu_result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_SHIFT = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic [2:0]       r_alu_op;
    logic             r_busy;
    logic             r_done;
    logic             w_accept;
    logic             w_last;
    logic             w_capture;

    assign w_accept  = (r_state == S_IDLE) && i_start;
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    // The first SHIFT cycle still sees the PRIME result on i_alu_result, so it is skipped.
    assign w_capture = ((r_state == S_SHIFT) && (r_cnt != '0)) || (r_state == S_DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_alu_enable = 1'b0;
        o_alu_start  = 1'b0;
        o_alu_rs1    = 1'b0;
        o_alu_rs2    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_PRIME;
            end
            S_PRIME: begin
                o_alu_enable = 1'b1;
                o_alu_start  = 1'b1;
                w_next       = S_SHIFT;
            end
            S_SHIFT: begin
                o_alu_enable = 1'b1;
                o_alu_rs1    = r_sa[0];
                o_alu_rs2    = r_sb[0];
                if (w_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_sa     <= '0;
            r_sb     <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_alu_op <= 3'b000;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_sa     <= i_a;
                r_sb     <= i_b;
                r_alu_op <= i_op;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
            end
            if (r_state == S_SHIFT) begin
                r_sa  <= r_sa >> 1;
                r_sb  <= r_sb >> 1;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_capture) begin
                r_acc <= {i_alu_result, r_acc[WIDTH-1:1]};
            end
            if (r_state == S_DRAIN) begin
                r_result <= {i_alu_result, r_acc[WIDTH-1:1]};
                r_done   <= 1'b1;
                r_busy   <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic r_nz;
    logic r_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nz   <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_nz <= 1'b0;
            end else if (w_capture) begin
                r_nz <= r_nz | i_alu_result;
            end
            if (r_state == S_DRAIN) begin
                r_zero <= ~(r_nz | i_alu_result);
            end
        end
    end

    assign o_zero = r_zero;
`endif

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_alu_op = r_alu_op;

    // busy must track "FSM not idle" exactly; done never overlaps busy.
    a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
        r_busy == (r_state != S_IDLE));
    a_done_idle: assert property (@(posedge clk) disable iff (!rst_n)
        r_done |-> !r_busy);

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq: drives a behavioural 1-bit ALU, checks table vectors,
// multi-cycle corner cases and randomized requests against an arithmetic reference.
module tb_alu_serial_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         i_start;
    logic [2:0]   i_op;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_result;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic         o_zero;
`endif
    logic         o_alu_rs1;
    logic         o_alu_rs2;
    logic [2:0]   o_alu_op;
    logic         o_alu_enable;
    logic         o_alu_start;
    logic         alu_res;
    logic         alu_c;

    int n_tests = 0;
    int n_fail  = 0;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_op         (i_op),
        .i_a          (i_a),
        .i_b          (i_b),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_result     (o_result),
`ifdef ALU_SEQ_ZERO_FLAG_EN
        .o_zero       (o_zero),
`endif
        .o_alu_rs1    (o_alu_rs1),
        .o_alu_rs2    (o_alu_rs2),
        .o_alu_op     (o_alu_op),
        .o_alu_enable (o_alu_enable),
        .o_alu_start  (o_alu_start),
        .i_alu_result (alu_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] fa(input logic x, input logic y, input logic c);
        return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

    // Behavioural 1-bit ALU with registered result and internal carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_c   <= 1'b0;
            alu_res <= 1'b0;
        end else if (o_alu_enable) begin
            if (o_alu_start) begin
                alu_c   <= (o_alu_op == 3'b001);
                alu_res <= 1'b0;
            end else begin
                case (o_alu_op)
                    3'b000:  {alu_c, alu_res} <= fa(o_alu_rs1, o_alu_rs2, alu_c);
                    3'b001:  {alu_c, alu_res} <= fa(o_alu_rs1, ~o_alu_rs2, alu_c);
                    3'b010:  alu_res <= o_alu_rs1 ^ o_alu_rs2;
                    3'b011:  alu_res <= o_alu_rs1 & o_alu_rs2;
                    3'b100:  alu_res <= o_alu_rs1 | o_alu_rs2;
                    default: alu_res <= 1'b0;
                endcase
            end
        end
    end

    function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a ^ b;
            3'b011:  return a & b;
            3'b100:  return a | b;
            default: return '0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or after the bound).
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit mid_pulse, output logic [W-1:0] res,
                         output int lat, output int busy_cnt);
        i_start = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        @(posedge clk);
        lat      = 0;
        busy_cnt = 0;
        @(negedge clk);
        i_start = 1'b0;
        while (!o_done && lat < 40) begin
            if (o_busy) busy_cnt++;
            i_a  = W'($urandom);
            i_b  = W'($urandom);
            i_op = 3'($urandom);
            if (mid_pulse && lat == 3) begin
                i_start = 1'b1;
                i_a     = 8'hFF;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        i_start = 1'b0;
        res = o_result;
        if (!o_done) check("done_timeout", 32'(lat), 32'(W + 2));
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic run_checked(input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] exp,
                               input string tag);
        logic [W-1:0] res;
        int lat, bc;
        do_op(op, a, b, 1'b0, res, lat, bc);
        check({tag, "_result"}, 32'(res), 32'(exp));
        check({tag, "_latency"}, 32'(lat), 32'(W + 2));
        check({tag, "_busy_cycles"}, 32'(bc), 32'(W + 2));
        check({tag, "_alu_op"}, 32'(o_alu_op), 32'(op));
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check({tag, "_zero"}, 32'(o_zero), 32'(exp == '0));
`endif
    endtask

    initial begin
        logic [W-1:0] res;
        logic [W-1:0] ra, rb, held;
        logic [2:0]   rop;
        int lat, bc, ndone;

        rst_n   = 1'b0;
        i_start = 1'b0;
        i_op    = '0;
        i_a     = '0;
        i_b     = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              32'({o_busy, o_done, o_result, o_alu_rs1, o_alu_rs2, o_alu_op, o_alu_enable, o_alu_start}),
              32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check("reset_zero", 32'(o_zero), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        vecs.push_back('{3'b000, 8'h3C, 8'h05, 8'h41});
        vecs.push_back('{3'b001, 8'h05, 8'h07, 8'hFE});
        vecs.push_back('{3'b000, 8'h01, 8'h01, 8'h02});
        vecs.push_back('{3'b010, 8'hC3, 8'hA5, 8'h66});
        vecs.push_back('{3'b011, 8'hC3, 8'hA5, 8'h81});
        vecs.push_back('{3'b100, 8'hC3, 8'hA5, 8'hE7});
        vecs.push_back('{3'b111, 8'hC3, 8'hA5, 8'h00});
        vecs.push_back('{3'b101, 8'hFF, 8'hFF, 8'h00});
        vecs.push_back('{3'b001, 8'h55, 8'h55, 8'h00});
        vecs.push_back('{3'b000, 8'h00, 8'h01, 8'h01});
        vecs.push_back('{3'b000, 8'hFF, 8'h01, 8'h00});
        vecs.push_back('{3'b001, 8'h00, 8'h01, 8'hFF});
        vecs.push_back('{3'b110, 8'h12, 8'h34, 8'h00});

        // Issued back-to-back: each request is raised in the previous done cycle.
        foreach (vecs[i]) run_checked(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        // start mid-operation is ignored and must not produce a second done.
        @(negedge clk);
        do_op(3'b000, 8'h10, 8'h20, 1'b1, res, lat, bc);
        check("midstart_result", 32'(res), 32'h30);
        check("midstart_latency", 32'(lat), 32'(W + 2));
        ndone = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (o_done || o_busy) ndone++;
        end
        check("midstart_no_second_op", 32'(ndone), 32'd0);

        // Reset during SHIFT.
        i_start = 1'b1;
        i_op    = 3'b000;
        i_a     = 8'h77;
        i_b     = 8'h11;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_shifting", 32'({o_busy, o_alu_enable}), 32'b11);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              32'({o_busy, o_done, o_result, o_alu_rs1, o_alu_rs2, o_alu_op, o_alu_enable, o_alu_start}),
              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (o_done || o_busy) ndone++;
        end
        check("midreset_no_done", 32'(ndone), 32'd0);
        run_checked(3'b000, 8'h01, 8'h02, 8'h03, "post_reset");

        // Randomized requests, sometimes back-to-back, sometimes with idle gaps.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom);
            ra  = W'($urandom);
            rb  = W'($urandom);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_checked(rop, ra, rb, ref_op(rop, ra, rb), $sformatf("rnd%0d", i));
            held = ref_op(rop, ra, rb);
            if (i % 8 == 0) begin
                @(negedge clk);
                check($sformatf("rnd%0d_result_held", i), 32'(o_result), 32'(held));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
